// File: rtl/bf16_pkg.sv
// Shared bfloat16 constants and field layout for the multiplier slice.
package bf16_pkg;

  localparam logic [14:0] BF16_NAN  = 15'h7F81;
  localparam logic [14:0] BF16_INF  = 15'h7F80;
  localparam logic [14:0] BF16_ZERO = 15'h0000;

  localparam int unsigned BF16_BIAS     = 127;
  localparam int unsigned RSP_DEPTH_DEF = 2;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bf16_t;

endpackage

// File: rtl/bfloat16_mult.sv
// Registered bfloat16 multiplier, 1-cycle latency, round-to-nearest-even.
// Subnormal inputs and underflowing results are flushed to signed zero.
module bfloat16_mult
  import bf16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_prod
);

  bf16_t       w_a;
  bf16_t       w_b;
  logic        w_sign;
  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [15:0] w_mprod;
  logic        w_norm, w_guard, w_sticky, w_rnd, w_carry;
  logic [6:0]  w_man;
  logic [7:0]  w_man_rnd;
  logic [9:0]  w_exp_sum;
  logic [15:0] w_res;

  assign w_a      = i_a;
  assign w_b      = i_b;
  assign w_sign   = w_a.sign ^ w_b.sign;
  assign w_a_zero = (w_a.exp == 8'h00);
  assign w_b_zero = (w_b.exp == 8'h00);
  assign w_a_inf  = (w_a.exp == 8'hFF) && (w_a.man == 7'd0);
  assign w_b_inf  = (w_b.exp == 8'hFF) && (w_b.man == 7'd0);
  assign w_a_nan  = (w_a.exp == 8'hFF) && (w_a.man != 7'd0);
  assign w_b_nan  = (w_b.exp == 8'hFF) && (w_b.man != 7'd0);

  // Significand product, normalisation and rounding
  assign w_mprod   = {8'd0, 1'b1, w_a.man} * {8'd0, 1'b1, w_b.man};
  assign w_norm    = w_mprod[15];
  assign w_man     = w_norm ? w_mprod[14:8] : w_mprod[13:7];
  assign w_guard   = w_norm ? w_mprod[7] : w_mprod[6];
  assign w_sticky  = w_norm ? (|w_mprod[6:0]) : (|w_mprod[5:0]);
  assign w_rnd     = w_guard & (w_sticky | w_man[0]);
  assign w_man_rnd = {1'b0, w_man} + {7'd0, w_rnd};
  assign w_carry   = w_man_rnd[7];
  assign w_exp_sum = {2'b00, w_a.exp} + {2'b00, w_b.exp} + {9'd0, w_norm} + {9'd0, w_carry};

  // Special-value selection and exponent range handling
  always_comb begin
    w_res = {w_sign, BF16_ZERO};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
      w_res = {w_sign, BF16_NAN};
    end else if (w_a_inf || w_b_inf) begin
      w_res = {w_sign, BF16_INF};
    end else if (w_a_zero || w_b_zero) begin
      w_res = {w_sign, BF16_ZERO};
    end else if (w_exp_sum >= 10'(BF16_BIAS + 255)) begin
      w_res = {w_sign, BF16_INF};
    end else if (w_exp_sum <= 10'(BF16_BIAS)) begin
      w_res = {w_sign, BF16_ZERO};
    end else begin
      w_res = {w_sign, 8'(w_exp_sum - 10'(BF16_BIAS)), w_man_rnd[6:0]};
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_prod <= 16'h0000;
    end else begin
      o_prod <= w_res;
    end
  end

endmodule

// File: rtl/bf16_mult_arbiter.sv
// Round-robin arbiter sharing one registered bf16 multiplier between
// NUM_REQ requesters, with ID tag stage and credit-controlled response queue.
module bf16_mult_arbiter
  import bf16_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic [NUM_REQ-1:0]   iReqValid,
  output logic [NUM_REQ-1:0]   oReqReady,
  input  logic [16*NUM_REQ-1:0] iReqA,
  input  logic [16*NUM_REQ-1:0] iReqB,
  output logic                 oRspValid,
  input  logic                 iRspReady,
  output logic [15:0]          oRspData,
  output logic [ID_W-1:0]      oRspId,
  output logic                 oBusy
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 2);

  logic [ID_W-1:0]  r_last;
  logic             r_s1_valid;
  logic [ID_W-1:0]  r_s1_id;
  logic [OCC_W-1:0] r_occ;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [15:0]      r_mem_data [RSP_DEPTH];
  logic [ID_W-1:0]  r_mem_id   [RSP_DEPTH];
  logic             r_rsp_valid;
  logic             r_busy;

  logic [CNT_W-1:0]   w_cnt;
  logic [OCC_W-1:0]   w_occ_nxt;
  logic               w_pop, w_push, w_eligible, w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic [NUM_REQ-1:0] w_ready;
  logic [15:0]        w_mul_a, w_mul_b, w_prod;
  int unsigned        w_best, w_dist;

  assign w_cnt      = CNT_W'(r_occ) + CNT_W'(r_s1_valid);
  assign w_pop      = r_rsp_valid & iRspReady;
  assign w_push     = r_s1_valid;
  assign w_occ_nxt  = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
  assign w_eligible = (w_cnt < CNT_W'(RSP_DEPTH)) || ((w_cnt == CNT_W'(RSP_DEPTH)) && w_pop);

  // Round-robin pick: smallest rotated distance from last+1 among valid requesters
  always_comb begin
    w_grant    = 1'b0;
    w_grant_id = '0;
    w_best     = NUM_REQ;
    w_dist     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_dist = k + NUM_REQ - 1 - 32'(r_last);
      if (w_dist >= NUM_REQ) w_dist = w_dist - NUM_REQ;
      if (iReqValid[k] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_grant    = 1'b1;
        w_grant_id = ID_W'(k);
      end
    end
    if (!w_eligible || !iRstN) w_grant = 1'b0;
  end

  // One-hot ready and operand mux of the granted requester (zero when idle)
  always_comb begin
    w_ready = '0;
    w_mul_a = 16'h0000;
    w_mul_b = 16'h0000;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_grant && (w_grant_id == ID_W'(k))) begin
        w_ready[k] = 1'b1;
        w_mul_a    = iReqA[16*k +: 16];
        w_mul_b    = iReqB[16*k +: 16];
      end
    end
  end

  bfloat16_mult u_mult (
    .clk    (iClk),
    .rst_n  (iRstN),
    .i_a    (w_mul_a),
    .i_b    (w_mul_b),
    .o_prod (w_prod)
  );

  // Pointer, tag stage and response queue state
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_last      <= ID_W'(NUM_REQ - 1);
      r_s1_valid  <= 1'b0;
      r_s1_id     <= '0;
      r_occ       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        r_mem_data[i] <= 16'h0000;
        r_mem_id[i]   <= '0;
      end
    end else begin
      if (w_grant) begin
        r_last  <= w_grant_id;
        r_s1_id <= w_grant_id;
      end
      r_s1_valid <= w_grant;
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_prod;
        r_mem_id[r_wr_ptr]   <= r_s1_id;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      r_occ       <= w_occ_nxt;
      r_rsp_valid <= (w_occ_nxt != '0);
      r_busy      <= w_grant | (w_occ_nxt != '0);
    end
  end

  assign oReqReady = w_ready;
  assign oRspValid = r_rsp_valid;
  assign oRspData  = r_mem_data[r_rd_ptr];
  assign oRspId    = r_mem_id[r_rd_ptr];
  assign oBusy     = r_busy;

endmodule
